if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_stage_pc_reg.sv | 27 ++
 rtl/if_stage.sv | 147 ++++++++++++++
 tb/tb_if_stage.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared core definitions for the instruction fetch stage: datapath width,
// the canonical NOP encoding and the fetch FSM state type.
package if_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter register: loads d_i when enabled, returns to the reset
// vector on synchronous reset.
module pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [XLEN-1:0] d_i,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else if (en_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: zero-latency inst_mem fetch into a one-entry
// output register with decode backpressure, redirect flush and fault trap.
//
// state | meaning
// BOOT  | single idle cycle after reset, no fetch
// RUN   | fetching, stalling on backpressure, accepting redirects
// TRAP  | halted on misaligned redirect or out-of-range PC; only rst exits
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              IMEM_DEPTH   = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] IMEMaddr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fault_pc,
  output logic [XLEN-1:0] fetch_count
);

  localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_DEPTH * 4);

  fetch_state_e    state_q, state_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic [XLEN-1:0] ipc4_q, ipc4_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;
  logic [XLEN-1:0] count_q, count_d;

  logic            pc_en;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic            transfer;

  pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .en_i (pc_en),
    .d_i  (pc_d),
    .q_o  (pc_q)
  );

  assign pc_plus4 = pc_q + 32'd4;
  assign transfer = valid_q && id_ready;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    ipc4_d     = ipc4_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;
    pc_en      = 1'b0;
    pc_d       = pc_plus4;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        // The held instruction is consumed even when a redirect or trap
        // happens in the same cycle.
        if (transfer) begin
          count_d = count_q + 32'd1;
        end

        if (redirect_valid) begin
          valid_d = 1'b0;
          if (is_misaligned(redirect_pc)) begin
            state_d    = ST_TRAP;
            fault_pc_d = redirect_pc;
          end else begin
            pc_en = 1'b1;
            pc_d  = redirect_pc;
          end
        end else if (!valid_q || id_ready) begin
          if (pc_q >= IMEM_LIMIT) begin
            state_d    = ST_TRAP;
            fault_pc_d = pc_q;
            valid_d    = 1'b0;
          end else begin
            valid_d = 1'b1;
            instr_d = imem_data;
            ipc_d   = pc_q;
            ipc4_d  = pc_plus4;
            pc_en   = 1'b1;
            pc_d    = pc_plus4;
          end
        end
      end

      ST_TRAP: begin
        state_d = ST_TRAP;
      end

      default: begin
        state_d = ST_BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      ipc_q      <= '0;
      ipc4_q     <= '0;
      fault_pc_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
      ipc4_q     <= ipc4_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  assign IMEMaddr    = pc_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ipc_q;
  assign if_pc4      = ipc4_q;
  assign fetch_fault = (state_q == ST_TRAP);
  assign fault_pc    = fault_pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a directed vector table for fetch, stall
// and redirect, plus sequences for misaligned trap, reset from TRAP and end of memory.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IMEMaddr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem [32];

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .IMEMaddr       (IMEMaddr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Word i holds 5*(i+1): words 0..3 are 5, 10, 15, 20.
  assign imem_data = (IMEMaddr < 32'd128) ? mem[IMEMaddr[6:2]] : 32'h0;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_addr;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'(5 * (i + 1));

    vecs[0]  = '{1'b1, 1'b0, 32'd0,  1'b0, 32'd0,  32'h13, 32'd0,  32'd0};
    vecs[1]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd0,  32'd5,  32'd4,  32'd0};
    vecs[2]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd4,  32'd10, 32'd8,  32'd1};
    vecs[3]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd4,  32'd10, 32'd8,  32'd1};
    vecs[4]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd4,  32'd10, 32'd8,  32'd1};
    vecs[5]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd4,  32'd10, 32'd8,  32'd1};
    vecs[6]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd8,  32'd15, 32'd12, 32'd2};
    vecs[7]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd12, 32'd20, 32'd16, 32'd3};
    vecs[8]  = '{1'b0, 1'b1, 32'd12, 1'b0, 32'd12, 32'd20, 32'd12, 32'd3};
    vecs[9]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd12, 32'd20, 32'd16, 32'd3};
    vecs[10] = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd12, 32'd20, 32'd0,  32'd4};
    vecs[11] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd0,  32'd5,  32'd4,  32'd4};
    vecs[12] = '{1'b0, 1'b1, 32'd8,  1'b0, 32'd0,  32'd5,  32'd8,  32'd4};
    vecs[13] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd8,  32'd15, 32'd12, 32'd4};

    rst = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, 32'h13);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pc4", if_pc4, 32'd0);
    chk("rst_addr", IMEMaddr, 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    chk("rst_count", fetch_count, 32'd0);

    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      id_ready = vecs[i].rdy; redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      step();
      chk($sformatf("v%0d_valid", i), 32'(if_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_pc", i), if_pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_instr", i), if_instr, vecs[i].exp_instr);
      chk($sformatf("v%0d_addr", i), IMEMaddr, vecs[i].exp_addr);
      chk($sformatf("v%0d_count", i), fetch_count, vecs[i].exp_cnt);
      if (i != 0) chk($sformatf("v%0d_pc4", i), if_pc4, vecs[i].exp_pc + 32'd4);
      chk($sformatf("v%0d_fault", i), 32'(fetch_fault), 32'd0);
    end

    // Misaligned redirect while a transfer is in flight: transfer counts, fetch halts.
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h6;
    step();
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_fault_pc", fault_pc, 32'd6);
    chk("mis_valid", 32'(if_valid), 32'd0);
    chk("mis_count", fetch_count, 32'd5);
    redirect_pc = 32'd0;
    for (int i = 0; i < 10; i++) begin
      redirect_valid = (i % 2 == 0);
      step();
      chk($sformatf("trap%0d_valid", i), 32'(if_valid), 32'd0);
      chk($sformatf("trap%0d_fault", i), 32'(fetch_fault), 32'd1);
      chk($sformatf("trap%0d_addr", i), IMEMaddr, 32'd12);
      chk($sformatf("trap%0d_fault_pc", i), fault_pc, 32'd6);
      chk($sformatf("trap%0d_count", i), fetch_count, 32'd5);
    end

    // One-cycle reset out of TRAP, redirect still asserted to show rst wins.
    redirect_valid = 1'b1; redirect_pc = 32'd16; rst = 1'b1;
    step();
    rst = 1'b0; redirect_valid = 1'b0;
    chk("trst_fault", 32'(fetch_fault), 32'd0);
    chk("trst_addr", IMEMaddr, 32'd0);
    chk("trst_count", fetch_count, 32'd0);
    chk("trst_fault_pc", fault_pc, 32'd0);
    step();
    chk("trst_boot_valid", 32'(if_valid), 32'd0);
    step();
    chk("trst_run_valid", 32'(if_valid), 32'd1);
    chk("trst_run_pc", if_pc, 32'd0);
    chk("trst_run_instr", if_instr, 32'd5);

    // Stream to the end of memory; expect a trap at 128 after 32 transfers.
    begin
      int n;
      n = 0;
      while (!fetch_fault && n < 100) begin
        step();
        n++;
        if (!fetch_fault && if_valid && if_pc == 32'd124)
          chk("last_instr", if_instr, 32'd160);
      end
      chk("end_timeout", 32'(n < 100), 32'd1);
      chk("end_cycles", 32'(n), 32'd32);
    end
    chk("end_fault", 32'(fetch_fault), 32'd1);
    chk("end_fault_pc", fault_pc, 32'd128);
    chk("end_count", fetch_count, 32'd32);
    chk("end_valid", 32'(if_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
